sram_rd_arbiter: RTL

- Shares the single instruction/data SRAM read port (AXI-lite style AR/R channels) between two requesters: the IFU fetch port and the LSU load port.
- Sits between the IFU/LSU and the SRAM model.
- Accepts one request at a time and forwards it downstream. Routes the response back to its owner only.
- Arbitration is round-robin, so neither requester starves.

---
 rtl/sram_rd_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sram_rd_arbiter.sv
// Round-robin arbiter sharing one AXI-lite style SRAM read port (AR/R) between
// the IFU fetch port and the LSU load port, one transaction in flight at a time.
module sram_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,

  input  logic [ADDR_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,

  output logic [ADDR_WIDTH-1:0] mem_araddr,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,

  output logic [1:0]            arb_owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IFU  = 2'b01;
  localparam logic [1:0] OWN_LSU  = 2'b10;

  state_t                  state_q, state_d;
  logic [1:0]              owner_q, owner_d;
  logic [1:0]              last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic ifu_win;
  logic lsu_win;
  logic owner_rready;

  // On a tie the IFU wins unless it was the last one served.
  assign ifu_win = ifu_arvalid && (!lsu_arvalid || (last_grant_q != OWN_IFU));
  assign lsu_win = lsu_arvalid && !ifu_win;

  assign owner_rready = ((owner_q == OWN_IFU) && ifu_rready) ||
                        ((owner_q == OWN_LSU) && lsu_rready);

  assign arb_owner = owner_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      last_grant_q <= OWN_LSU;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;

    ifu_arready  = 1'b0;
    lsu_arready  = 1'b0;
    ifu_rvalid   = 1'b0;
    ifu_rdata    = '0;
    ifu_rresp    = 2'b00;
    lsu_rvalid   = 1'b0;
    lsu_rdata    = '0;
    lsu_rresp    = 2'b00;
    mem_arvalid  = 1'b0;
    mem_araddr   = '0;
    mem_rready   = 1'b0;

    case (state_q)
      IDLE: begin
        // arready is gated by reset so no handshake can complete while held in reset.
        ifu_arready = ifu_win && rst;
        lsu_arready = lsu_win && rst;
        if (ifu_win) begin
          addr_d  = ifu_araddr;
          owner_d = OWN_IFU;
          state_d = ISSUE;
        end else if (lsu_win) begin
          addr_d  = lsu_araddr;
          owner_d = OWN_LSU;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        mem_arvalid = 1'b1;
        mem_araddr  = addr_q;
        if (mem_arready) begin
          state_d = WAIT_R;
        end
      end

      WAIT_R: begin
        mem_rready = owner_rready;
        if (owner_q == OWN_IFU) begin
          ifu_rvalid = mem_rvalid;
          ifu_rdata  = mem_rdata;
          ifu_rresp  = mem_rresp;
        end else if (owner_q == OWN_LSU) begin
          lsu_rvalid = mem_rvalid;
          lsu_rdata  = mem_rdata;
          lsu_rresp  = mem_rresp;
        end
        if (mem_rvalid && owner_rready) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
          owner_d      = OWN_NONE;
        end
      end

      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

endmodule
